io_responder: RTL
=================

Name: io_responder

Overview:
- Peripheral-side endpoint of the core's simple memory-mapped IO bus. The core drives address, data, write/read select and byte strobes, and expects read data back with a valid pulse.
- Decodes a 256-byte window at BASE_ADDR containing eight scratch registers, a 64-bit free-running time counter, a 64-bit compare register, control/status registers and a timer interrupt.
- Read data returns after a fixed, parameterised latency. There is no backpressure: one request is accepted every cycle.

Parameters:
- BASE_ADDR, 32'h8000_0000, window base; must be 256-byte aligned.
- READ_LATENCY, 1, cycles from addr_en to s_axi_rvalid; legal range 1..4.
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- addr_en  in  1  request strobe, one request per cycle
- s_axi_addr  in  32  byte address
- s_axi_wdata  in  32  write data
- w_nrr  in  1  1 = write, 0 = read
- wstrb  in  4  byte enables for writes
- s_axi_rdata  out  32  read data
- s_axi_rvalid  out  1  read data valid, single-cycle pulse per read
- irq  out  1  timer interrupt, level

Behaviour:
- Reset values: s_axi_rdata = 0, s_axi_rvalid = 0, irq = 0, all registers 0, read pipeline empty, tick prescaler 0.
- Decode: hit = addr_en && (s_axi_addr[31:8] == BASE_ADDR[31:8]). Word offset = s_axi_addr[7:2]; s_axi_addr[1:0] is ignored.
- Register map (byte offsets):
  - 0x00–0x1C: scratch[0..7], RW.
  - 0x20: mtime_lo, RO.
  - 0x24: mtime_hi_snap, RO; holds mtime[63:32] latched at the most recent mtime_lo read.
  - 0x28: cmp_lo, RW. 0x2C: cmp_hi, RW.
  - 0x30: ctrl, RW; bit0 timer_en, bit1 irq_en, other bits read 0.
  - 0x34: status; bit0 pending, write-1-to-clear.
  - 0x38: err_cnt (optional feature only).
  - Other offsets: reads return 0, writes are ignored.
- Writes:
  - Apply at the clock edge ending the addr_en cycle; byte lane i updates only when wstrb[i] = 1.
  - For status, only lane 0 with wdata[0] = 1 clears pending.
  - Writes to RO registers are ignored. A write produces no rvalid.
- Reads:
  - Data is sampled from register state as it stands in the request cycle (pre-write values).
  - Data shifts through READ_LATENCY stages; s_axi_rvalid = 1 and s_axi_rdata are valid exactly READ_LATENCY cycles after addr_en.
  - A read miss (address outside the window) still returns rdata = 0 with rvalid, so the core never hangs.
  - Back-to-back reads produce back-to-back rvalid in order.
  - s_axi_rdata holds its last value when rvalid = 0.
- Timer:
  - While timer_en = 1, the prescaler counts 0..TICK_DIV-1; on wrap, mtime increments by 1, with 64-bit wrap-around to 0.
  - Clearing timer_en freezes both mtime and the prescaler.
- Pending:
  - Set on any cycle with timer_en && (mtime >= {cmp_hi, cmp_lo}), unsigned compare.
  - If set and W1C occur in the same cycle, set wins.
  - irq = pending & irq_en, registered, so it follows pending one cycle later.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is issued after reset is asserted.

Optional Feature:
- Macro: IO_RESPONDER_ERR_CNT_EN.
- Defined: offset 0x38 is err_cnt, a 16-bit saturating counter (upper bits read 0).
  - Increments on any addr_en whose address misses the window, and on writes to RO offsets 0x20/0x24.
  - Any write to 0x38 clears it.
- Undefined: 0x38 reads 0 and no counter logic exists.

Decomposition:
- Package io_responder_pkg holds:
  - register offset constants (OFF_SCRATCH0 … OFF_ERRCNT);
  - the ctrl bit-index constants;
  - a struct typedef io_req_t {addr, wdata, wr, strb}.
- One sub-module, io_read_pipe: a parameterised READ_LATENCY-deep valid/data shift register with synchronous clear.

Test Plan:
- Reset then read scratch0 (0x8000_0000), READ_LATENCY = 2 -> rvalid pulses at cycle +2 with rdata = 0.
- Write scratch3 = 0xAABBCCDD with wstrb = 4'b0101, then read scratch3 -> 0x00BB00DD.
- Read 0x8000_0100 (miss) -> rvalid at latency with rdata = 0; with IO_RESPONDER_ERR_CNT_EN, a following read of 0x38 returns 1.
- TICK_DIV = 1, cmp = 5, ctrl = 3 -> pending sets when mtime reaches 5 and irq rises one cycle later. W1C to status in the same cycle as the set condition -> pending stays 1.
- mtime preloaded to 0x0000_0000_FFFF_FFFF with timer_en = 0; read lo, then set timer_en and read hi -> lo = 0xFFFF_FFFF, hi_snap = 0 (snapshot, not live value).
- Issue 3 back-to-back reads, assert rst the next cycle -> no rvalid observed after reset; all outputs at reset values.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Register offsets, ctrl bit positions and the request struct for io_responder.
package io_responder_pkg;

  localparam logic [7:0] OFF_SCRATCH0 = 8'h00;
  localparam logic [7:0] OFF_MTIME_LO = 8'h20;
  localparam logic [7:0] OFF_MTIME_HI = 8'h24;
  localparam logic [7:0] OFF_CMP_LO   = 8'h28;
  localparam logic [7:0] OFF_CMP_HI   = 8'h2C;
  localparam logic [7:0] OFF_CTRL     = 8'h30;
  localparam logic [7:0] OFF_STATUS   = 8'h34;
  localparam logic [7:0] OFF_ERRCNT   = 8'h38;

  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  strb;
  } io_req_t;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    merge_strb = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merge_strb[8*i +: 8] = new_val[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/io_read_pipe.sv
// Fixed-latency read return: LATENCY-deep valid/data shift register, sync clear.
// Each stage's data only loads behind a valid, so the output data holds between pulses.
module io_read_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] in_dat,
  output logic        out_vld,
  output logic [31:0] out_dat
);

  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0][31:0] dat_q, dat_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_vld;
    if (in_vld) dat_d[0] = in_dat;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO endpoint: scratch regs, 64-bit timer with compare/irq, fixed read latency.
// Optional saturating error counter at 0x38 enabled by IO_RESPONDER_ERR_CNT_EN.
module io_responder
  import io_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          READ_LATENCY = 1,
  parameter int          TICK_DIV     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_en,
  input  logic [31:0] s_axi_addr,
  input  logic [31:0] s_axi_wdata,
  input  logic        w_nrr,
  input  logic [3:0]  wstrb,
  output logic [31:0] s_axi_rdata,
  output logic        s_axi_rvalid,
  output logic        irq
);

  io_req_t req;
  assign req = '{addr: s_axi_addr, wdata: s_axi_wdata, wr: w_nrr, strb: wstrb};

  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = req.addr[1:0];

  logic [7:0][31:0] scratch_q, scratch_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic [31:0]      snap_q, snap_d;
  logic [15:0]      presc_q, presc_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             pending_q, pending_d;
  logic             irq_q, irq_d;
`ifdef IO_RESPONDER_ERR_CNT_EN
  logic [15:0]      err_cnt_q, err_cnt_d;
`endif

  logic [7:0]  off;
  logic        hit, wr_hit, rd_req, is_scratch;
  logic [31:0] rd_dat;

  always_comb begin
    off        = {req.addr[7:2], 2'b00};
    hit        = addr_en && (req.addr[31:8] == BASE_ADDR[31:8]);
    wr_hit     = hit && req.wr;
    rd_req     = addr_en && !req.wr;
    is_scratch = (off[7:5] == OFF_SCRATCH0[7:5]);

    // Read mux sees pre-write state; misses fall through to zero.
    rd_dat = '0;
    if (hit) begin
      if (is_scratch) begin
        rd_dat = scratch_q[off[4:2]];
      end else begin
        case (off)
          OFF_MTIME_LO: rd_dat = mtime_q[31:0];
          OFF_MTIME_HI: rd_dat = snap_q;
          OFF_CMP_LO:   rd_dat = cmp_q[31:0];
          OFF_CMP_HI:   rd_dat = cmp_q[63:32];
          OFF_CTRL:     rd_dat = {30'b0, ctrl_q};
          OFF_STATUS:   rd_dat = {31'b0, pending_q};
`ifdef IO_RESPONDER_ERR_CNT_EN
          OFF_ERRCNT:   rd_dat = {16'b0, err_cnt_q};
`else
          OFF_ERRCNT:   rd_dat = '0;
`endif
          default:      rd_dat = '0;
        endcase
      end
    end

    scratch_d = scratch_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    snap_d    = snap_q;
    mtime_d   = mtime_q;
    presc_d   = presc_q;

    if (wr_hit) begin
      if (is_scratch) begin
        scratch_d[off[4:2]] = merge_strb(scratch_q[off[4:2]], req.wdata, req.strb);
      end else begin
        case (off)
          OFF_CMP_LO: cmp_d[31:0]  = merge_strb(cmp_q[31:0], req.wdata, req.strb);
          OFF_CMP_HI: cmp_d[63:32] = merge_strb(cmp_q[63:32], req.wdata, req.strb);
          OFF_CTRL:   if (req.strb[0]) ctrl_d = req.wdata[1:0];
          default:    ;
        endcase
      end
    end

    if (hit && !req.wr && off == OFF_MTIME_LO) snap_d = mtime_q[63:32];

    if (ctrl_q[CTRL_TIMER_EN]) begin
      if (presc_q == 16'(TICK_DIV - 1)) begin
        presc_d = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    // Set is evaluated last so it wins over a same-cycle clear.
    pending_d = pending_q;
    if (wr_hit && off == OFF_STATUS && req.strb[0] && req.wdata[0]) pending_d = 1'b0;
    if (ctrl_q[CTRL_TIMER_EN] && (mtime_q >= cmp_q)) pending_d = 1'b1;

    irq_d = pending_q & ctrl_q[CTRL_IRQ_EN];

`ifdef IO_RESPONDER_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
    if (wr_hit && off == OFF_ERRCNT) begin
      err_cnt_d = '0;
    end else if ((addr_en && !hit) ||
                 (wr_hit && (off == OFF_MTIME_LO || off == OFF_MTIME_HI))) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      mtime_q   <= '0;
      cmp_q     <= '0;
      snap_q    <= '0;
      presc_q   <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
`ifdef IO_RESPONDER_ERR_CNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      scratch_q <= scratch_d;
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      snap_q    <= snap_d;
      presc_q   <= presc_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
`ifdef IO_RESPONDER_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign irq = irq_q;

  io_read_pipe #(
    .LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_req),
    .in_dat  (rd_dat),
    .out_vld (s_axi_rvalid),
    .out_dat (s_axi_rdata)
  );

endmodule
